// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit:
// opcodes, default latencies and FSM encoding.
package mdu_pkg;

    localparam int MDOP_W = 3;

    typedef logic [MDOP_W-1:0] mdop_t;

    localparam mdop_t MDOP_MULT  = 3'd0;
    localparam mdop_t MDOP_MULTU = 3'd1;
    localparam mdop_t MDOP_DIV   = 3'd2;
    localparam mdop_t MDOP_DIVU  = 3'd3;
    localparam mdop_t MDOP_MTHI  = 3'd4;
    localparam mdop_t MDOP_MTLO  = 3'd5;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    function automatic logic is_md(mdop_t op);
        return op <= MDOP_DIVU;
    endfunction

    function automatic logic is_div(mdop_t op);
        return (op == MDOP_DIV) || (op == MDOP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_if.sv
// Issue/result bundle between the EX stage and the MDU.
// The master issues operations; the slave owns HI/LO.
interface mdu_if
    import mdu_pkg::*;
();

    logic        start;
    mdop_t       mdop;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, mdop, a, b,
        input  busy, hi, lo
    );

    modport slave (
        input  start, mdop, a, b,
        output busy, hi, lo
    );

endinterface

// File: rtl/mdu_arith.sv
// Combinational MIPS mult/div result generator.
// Ops that produce no result return the current HI/LO.
module mdu_arith
    import mdu_pkg::*;
(
    input  mdop_t       mdop_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    output logic [63:0] res_o
);

    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic               sgn;
    logic               a_neg;
    logic               b_neg;
    logic        [31:0] ua;
    logic        [31:0] ub;
    logic        [31:0] q;
    logic        [31:0] r;

    // Signed divide works on magnitudes so the
    // 0x80000000 / -1 case falls out without overflow.
    always_comb begin
        sa    = {{32{a_i[31]}}, a_i};
        sb    = {{32{b_i[31]}}, b_i};
        sgn   = (mdop_i == MDOP_DIV);
        a_neg = sgn & a_i[31];
        b_neg = sgn & b_i[31];
        ua    = a_neg ? -a_i : a_i;
        ub    = b_neg ? -b_i : b_i;
        q     = (ub == '0) ? '0 : ua / ub;
        r     = (ub == '0) ? '0 : ua % ub;
        res_o = {hi_i, lo_i};
        unique case (1'b1)
            (mdop_i == MDOP_MULT):
                res_o = 64'(sa * sb);
            (mdop_i == MDOP_MULTU):
                res_o = {32'b0, a_i} * {32'b0, b_i};
            is_div(mdop_i) && (ub != '0): begin
                res_o[31:0]  = (a_neg ^ b_neg) ? -q : q;
                res_o[63:32] = a_neg ? -r : r;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU sequencer: latency countdown, pending result,
// and the architectural HI/LO registers.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic  clk,
    input  logic  reset,
    mdu_if.slave  bus
);

    localparam int MAXL =
        (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAXL) + 1;

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   pend_hi_q, pend_hi_d;
    logic [31:0]   pend_lo_q, pend_lo_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic [63:0]   res;

    mdu_arith u_arith (
        .mdop_i (bus.mdop),
        .a_i    (bus.a),
        .b_i    (bus.b),
        .hi_i   (hi_q),
        .lo_i   (lo_q),
        .res_o  (res)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    // Starts during BUSY are dropped; hazard control prevents them.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    unique case (1'b1)
                        is_md(bus.mdop): begin
                            pend_hi_d = res[63:32];
                            pend_lo_d = res[31:0];
                            count_d   = is_div(bus.mdop)
                                      ? CW'(DIV_CYCLES)
                                      : CW'(MULT_CYCLES);
                            state_d   = S_BUSY;
                        end
                        (bus.mdop == MDOP_MTHI): hi_d = bus.a;
                        (bus.mdop == MDOP_MTLO): lo_d = bus.a;
                        default: ;
                    endcase
                end
            end
            S_BUSY: begin
                count_d = count_q - 1'b1;
                if (count_q == CW'(1)) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy = (state_q == S_BUSY);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule
